coherence_bus_arbiter: RTL and testbench

Sequencer for the shared snoopy coherence bus in the multicore cache subsystem. Arbitrates miss and upgrade requests from NCORES private L1 controllers round-robin, broadcasts the winning request as a snoop, and collects hit/dirty responses. It also sequences any dirty-owner flush and the memory fetch. On completion it returns to the requester the MESI action code its per-line status controller consumes to pick the next state (S vs E on read miss, M on write).

---
 rtl/coh_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/coherence_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coh_pkg.sv
// Shared types and codes for the snoopy coherence bus sequencer:
// bus ops, MESI response actions, MESI line states and sequencer states.
package coh_pkg;

    typedef enum logic [1:0] {
        op_none = 2'b00,
        op_rd   = 2'b01,
        op_rdx  = 2'b10,
        op_upgr = 2'b11
    } bus_op_t;

    localparam logic [2:0] act_write_hit           = 3'b000;
    localparam logic [2:0] act_read_hit            = 3'b001;
    localparam logic [2:0] act_write_miss          = 3'b010;
    localparam logic [2:0] act_read_miss_exclusive = 3'b011;
    localparam logic [2:0] act_read_miss_share     = 3'b100;

    localparam logic [1:0] mesi_i = 2'b00;
    localparam logic [1:0] mesi_m = 2'b01;
    localparam logic [1:0] mesi_s = 2'b10;
    localparam logic [1:0] mesi_e = 2'b11;

    typedef enum logic [2:0] {
        st_idle,
        st_snoop,
        st_collect,
        st_flush,
        st_fetch,
        st_done
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] id
);

    int idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt = '0;
        id  = '0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                id       = W'(idx);
            end
        end
    end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snoopy coherence bus sequencer: round-robin arbitration, snoop broadcast,
// response collection, dirty-owner flush, memory fetch and MESI action return.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// st_idle    | pick a requester, latch its id/op/address
// st_snoop   | broadcast the latched request, grant rises
// st_collect | sample hit/dirty from other cores, choose action and path
// st_flush   | write back the dirty owner's line, wait for mem_ready
// st_fetch   | read the line from memory, wait for mem_ready
// st_done    | pulse done to the owner with resp_action, advance rr_ptr
module coherence_bus_arbiter
    import coh_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int ADDR_W = 32,
    parameter int CID_W  = $clog2(NCORES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCORES-1:0]             req_valid,
    input  logic [NCORES-1:0][1:0]        req_op,
    input  logic [NCORES-1:0][ADDR_W-1:0] req_addr,
    output logic [NCORES-1:0]             grant,
    output logic [NCORES-1:0]             done,
    output logic [2:0]                    resp_action,
    output logic                          snoop_valid,
    output logic [1:0]                    snoop_op,
    output logic [ADDR_W-1:0]             snoop_addr,
    output logic [CID_W-1:0]              snoop_src,
    input  logic [NCORES-1:0]             snoop_hit,
    input  logic [NCORES-1:0]             snoop_dirty,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready
);

    arb_state_t          state;
    logic [CID_W-1:0]    rr_ptr;
    logic [CID_W-1:0]    win_id;
    logic [NCORES-1:0]   win_oh;
    bus_op_t             lat_op;
    logic [ADDR_W-1:0]   lat_addr;
    logic [2:0]          act_q;

    logic [NCORES-1:0]   req_mask;
    logic [NCORES-1:0]   arb_gnt;
    logic [CID_W-1:0]    arb_id;
    logic                shared_any;
    logic                dirty_any;

    always_comb begin
        req_mask = '0;
        for (int i = 0; i < NCORES; i++) begin
            req_mask[i] = req_valid[i] & (req_op[i] != 2'b00);
        end
    end

    rr_arbiter #(.N(NCORES), .W(CID_W)) u_rr_arbiter (
        .req (req_mask),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    // The requester's own snoop response never counts as a sharer.
    assign shared_any = |(snoop_hit   & ~win_oh);
    assign dirty_any  = |(snoop_dirty & ~win_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= st_idle;
            rr_ptr   <= '0;
            win_id   <= '0;
            win_oh   <= '0;
            lat_op   <= op_none;
            lat_addr <= '0;
            act_q    <= act_write_hit;
        end else begin
            case (state)
                st_idle: begin
                    if (|req_mask) begin
                        win_id   <= arb_id;
                        win_oh   <= arb_gnt;
                        lat_op   <= bus_op_t'(req_op[arb_id]);
                        lat_addr <= req_addr[arb_id];
                        state    <= st_snoop;
                    end
                end
                st_snoop: state <= st_collect;
                st_collect: begin
                    case (lat_op)
                        op_upgr: begin
                            act_q <= act_write_hit;
                            state <= st_done;
                        end
                        op_rdx: begin
                            act_q <= act_write_miss;
                            state <= dirty_any ? st_flush : st_fetch;
                        end
                        default: begin
                            // A flushing owner keeps the line in S, so dirty also means shared.
                            act_q <= (shared_any | dirty_any) ? act_read_miss_share
                                                              : act_read_miss_exclusive;
                            state <= dirty_any ? st_flush : st_fetch;
                        end
                    endcase
                end
                st_flush: if (mem_ready) state <= st_fetch;
                st_fetch: if (mem_ready) state <= st_done;
                st_done: begin
                    rr_ptr <= (win_id == CID_W'(NCORES - 1)) ? '0 : win_id + CID_W'(1);
                    state  <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign grant       = (state != st_idle) ? win_oh : '0;
    assign done        = (state == st_done) ? win_oh : '0;
    assign resp_action = (state == st_done) ? act_q : 3'b000;
    assign snoop_valid = (state == st_snoop);
    assign snoop_op    = lat_op;
    assign snoop_addr  = lat_addr;
    assign snoop_src   = win_id;
    assign mem_req     = (state == st_flush) || (state == st_fetch);
    assign mem_we      = (state == st_flush);
    assign mem_addr    = lat_addr;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_coherence_bus_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NC-1:0]        req_valid;
    logic [NC-1:0][1:0]   req_op;
    logic [NC-1:0][AW-1:0] req_addr;
    logic [NC-1:0]        grant, done;
    logic [2:0]           resp_action;
    logic                 snoop_valid;
    logic [1:0]           snoop_op;
    logic [AW-1:0]        snoop_addr;
    logic [1:0]           snoop_src;
    logic [NC-1:0]        snoop_hit, snoop_dirty;
    logic                 mem_req, mem_we;
    logic [AW-1:0]        mem_addr;
    logic                 mem_ready;

    coherence_bus_arbiter #(.NCORES(NC), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .grant(grant), .done(done), .resp_action(resp_action), .snoop_valid(snoop_valid),
        .snoop_op(snoop_op), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction model: one request in flight, aged in cycles since its arbitration cycle.
    bit          m_busy;
    int          m_age, m_win, m_mem_left, m_ptr, m_arb_cyc, m_done_win;
    logic [2:0]  m_resp;
    logic [1:0]  m_lop;
    logic [31:0] m_laddr;
    int          m_lsrc;
    bit          m_done_evt;
    int          cyc;

    int          mode;
    logic [31:0] d_lo;

    int          win_q[$], lat_q[$], src_lat_q[$];
    logic [2:0]  resp_q[$];
    int          we_cnt, mreq_cnt, obs_src;
    logic [31:0] obs_saddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2id(input logic [NC-1:0] v);
        int id = -1;
        int n = 0;
        for (int i = 0; i < NC; i++) if (v[i] === 1'b1) begin id = i; n++; end
        return (n == 1) ? id : -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_ptr = 0; m_lop = 2'b00; m_laddr = '0; m_lsrc = 0;
        m_mem_left = 0; m_resp = 3'b000; m_win = 0;
    endtask

    task automatic check_outputs();
        logic [NC-1:0] e_grant, e_done;
        logic [2:0]    e_resp;
        logic          e_sv, e_mreq, e_mwe;
        e_grant = '0; e_done = '0; e_resp = 3'b000; e_sv = 0; e_mreq = 0; e_mwe = 0;
        if (m_busy) begin
            e_grant = NC'(1 << m_win);
            if (m_age == 1) e_sv = 1;
            else if (m_age >= 3) begin
                if (m_mem_left > 0) begin
                    e_mreq = 1;
                    e_mwe  = (m_mem_left == 2);
                end else begin
                    e_done = NC'(1 << m_win);
                    e_resp = m_resp;
                end
            end
        end
        chk("grant", 64'(grant), 64'(e_grant));
        chk("done", 64'(done), 64'(e_done));
        chk("resp_action", 64'(resp_action), 64'(e_resp));
        chk("snoop_valid", 64'(snoop_valid), 64'(e_sv));
        chk("snoop_op", 64'(snoop_op), 64'(m_lop));
        chk("snoop_addr", 64'(snoop_addr), 64'(m_laddr));
        chk("snoop_src", 64'(snoop_src), 64'(m_lsrc));
        chk("mem_req", 64'(mem_req), 64'(e_mreq));
        chk("mem_we", 64'(mem_we), 64'(e_mwe));
        chk("mem_addr", 64'(mem_addr), 64'(m_laddr));
        if (snoop_valid === 1'b1) begin
            obs_src = int'(snoop_src);
            obs_saddr = snoop_addr;
            src_lat_q.push_back(cyc - m_arb_cyc);
        end
        if (mem_we === 1'b1) we_cnt++;
        if (mem_req === 1'b1) mreq_cnt++;
        if (|done) begin
            win_q.push_back(oh2id(done));
            lat_q.push_back(cyc - m_arb_cyc);
            resp_q.push_back(resp_action);
        end
    endtask

    task automatic model_advance();
        bit sh, dy;
        m_done_evt = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_ptr + i) % NC;
                if (req_valid[c] && req_op[c] != 2'b00) begin
                    m_busy = 1; m_win = c; m_age = 1; m_arb_cyc = cyc;
                    m_lop = req_op[c]; m_laddr = req_addr[c]; m_lsrc = c;
                    break;
                end
            end
        end else if (m_age == 2) begin
            sh = 0; dy = 0;
            for (int j = 0; j < NC; j++) if (j != m_win) begin
                sh |= snoop_hit[j];
                dy |= snoop_dirty[j];
            end
            if (m_lop == 2'b01)      m_resp = (sh || dy) ? 3'b100 : 3'b011;
            else if (m_lop == 2'b10) m_resp = 3'b010;
            else                     m_resp = 3'b000;
            m_mem_left = (m_lop == 2'b11) ? 0 : (dy ? 2 : 1);
            m_age++;
        end else if (m_age >= 3 && m_mem_left == 0) begin
            m_busy = 0; m_ptr = (m_win + 1) % NC; m_done_evt = 1; m_done_win = m_win;
        end else begin
            if (m_age >= 3 && mem_ready) m_mem_left--;
            m_age++;
        end
        cyc++;
    endtask

    task automatic rand_drive();
        for (int i = 0; i < NC; i++) begin
            if ($urandom_range(5) == 0) begin
                req_valid[i] = ($urandom_range(4) != 0);
                req_op[i]    = 2'($urandom_range(3));
                req_addr[i]  = $urandom;
            end
        end
        snoop_hit   = NC'($urandom);
        snoop_dirty = NC'($urandom) & snoop_hit & {NC{$urandom_range(3) == 0}};
        mem_ready   = ($urandom_range(2) != 0);
    endtask

    task automatic step();
        if (mode == 3) rand_drive();
        else mem_ready = !d_lo[m_busy ? (m_age & 31) : 0];
        @(negedge clk);
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        win_q.delete(); lat_q.delete(); resp_q.delete(); src_lat_q.delete();
        we_cnt = 0; mreq_cnt = 0; obs_src = -1; obs_saddr = '0;
    endtask

    task automatic run_txn(input int budget, input bit release_req);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_done_evt && n < budget);
        chk("txn_timeout", 64'(m_done_evt), 64'd1);
        if (release_req) req_valid = '0;
    endtask

    task automatic single(input int core, input logic [1:0] op, input logic [31:0] addr,
                          input logic [NC-1:0] hit, input logic [NC-1:0] dirty,
                          input logic [31:0] lo_mask);
        req_valid = '0; req_op = '0; req_addr = '0;
        req_valid[core] = 1'b1; req_op[core] = op; req_addr[core] = addr;
        snoop_hit = hit; snoop_dirty = dirty; d_lo = lo_mask;
        clear_obs();
        run_txn(40, 1);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 1; d_lo = '0; cyc = 0; m_arb_cyc = 0;
        req_valid = '0; req_op = '0; req_addr = '0;
        snoop_hit = '0; snoop_dirty = '0; mem_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_obs();

        // Reset state
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_snoop_addr", 64'(snoop_addr), 64'd0);

        // Clean read: core 1 BusRd 0x40
        single(1, 2'b01, 32'h40, 4'b0000, 4'b0000, 32'h0);
        chk("clean_src", 64'(obs_src), 64'd1);
        chk("clean_snoop_lat", 64'(src_lat_q[0]), 64'd1);
        chk("clean_saddr", 64'(obs_saddr), 64'h40);
        chk("clean_win", 64'(win_q[0]), 64'd1);
        chk("clean_lat", 64'(lat_q[0]), 64'd4);
        chk("clean_resp", 64'(resp_q[0]), 64'b011);
        chk("clean_we", 64'(we_cnt), 64'd0);

        // Shared read: another core holds the line
        single(0, 2'b01, 32'h80, 4'b0100, 4'b0000, 32'h0);
        chk("shared_resp", 64'(resp_q[0]), 64'b100);
        chk("shared_we", 64'(we_cnt), 64'd0);

        // Requester's own hit must not count
        single(0, 2'b01, 32'hC0, 4'b0001, 4'b0001, 32'h0);
        chk("self_resp", 64'(resp_q[0]), 64'b011);
        chk("self_lat", 64'(lat_q[0]), 64'd4);

        // Dirty owner: two stall cycles in flush and two in fetch -> 4 + 1 + 4
        single(2, 2'b10, 32'h100, 4'b1000, 4'b1000, 32'h0000_00D8);
        chk("dirty_resp", 64'(resp_q[0]), 64'b010);
        chk("dirty_lat", 64'(lat_q[0]), 64'd9);
        chk("dirty_we_cycles", 64'(we_cnt), 64'd3);
        chk("dirty_mreq_cycles", 64'(mreq_cnt), 64'd6);

        // Fairness with continuous upgrades from reset
        req_valid = '0;
        do_reset();
        clear_obs();
        d_lo = '0; snoop_hit = '0; snoop_dirty = '0;
        for (int i = 0; i < NC; i++) begin
            req_valid[i] = 1'b1; req_op[i] = 2'b11; req_addr[i] = 32'h1000 + 32'(i * 64);
        end
        for (int t = 0; t < 5; t++) run_txn(20, 0);
        chk("fair_count", 64'(win_q.size()), 64'd5);
        if (win_q.size() == 5) begin
            for (int t = 0; t < 5; t++) begin
                chk("fair_order", 64'(win_q[t]), 64'(t % NC));
                chk("fair_lat", 64'(lat_q[t]), 64'd3);
                chk("fair_resp", 64'(resp_q[t]), 64'b000);
            end
        end
        chk("fair_no_mem", 64'(mreq_cnt), 64'd0);
        req_valid = '0;
        step();

        // Reset mid-fetch aborts; re-issued request from core 3 wins afterwards
        clear_obs();
        req_valid[3] = 1'b1; req_op[3] = 2'b01; req_addr[3] = 32'h200;
        d_lo = 32'hFFFF_FFFF;
        for (int n = 0; n < 10 && !(m_busy && m_age == 4); n++) step();
        chk("mid_fetch_reached", 64'(m_busy && m_age == 4), 64'd1);
        chk("mid_fetch_mreq", 64'(mem_req), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_mem_req", 64'(mem_req), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_saddr", 64'(snoop_addr), 64'd0);
        d_lo = '0;
        clear_obs();
        run_txn(20, 1);
        chk("reissue_win", 64'(win_q.size() > 0 ? win_q[0] : -1), 64'd3);
        chk("reissue_lat", 64'(lat_q.size() > 0 ? lat_q[0] : -1), 64'd4);
        step();

        // Randomized traffic
        mode = 3;
        clear_obs();
        for (int n = 0; n < 4000; n++) step();
        checks++;
        if (win_q.size() < 100) begin
            errors++;
            $display("FAIL random_throughput actual=%0d required>=100", win_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
